// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: counts rising edges of the divider tick while running,
// under Start/Stop/Clear button control, and keeps the time in BCD.
module stopwatch_counter #(
    parameter int MaxMinTens = 5
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       TickIn,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Clear,
    output logic [3:0] Sec0,
    output logic [3:0] Sec1,
    output logic [3:0] Min0,
    output logic [3:0] Min1,
    output logic       Running,
    output logic       Wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] SEC0_MAX = 4'd9;
    localparam logic [3:0] SEC1_MAX = 4'd5;
    localparam logic [3:0] MIN0_MAX = 4'd9;
    localparam logic [3:0] MIN1_MAX = 4'(MaxMinTens);

    state_t state;
    state_t state_next;

    logic tick_prev;
    logic start_prev;
    logic stop_prev;
    logic clear_prev;

    logic tick_evt;
    logic start_evt;
    logic stop_evt;
    logic clear_evt;

    logic       count_en;
    logic [4:0] sec0_step;
    logic [4:0] sec1_step;
    logic [4:0] min0_step;
    logic [4:0] min1_step;
    logic       wrap_next;

    // Advance one BCD digit when carry_in is set; returns {carry_out, digit}.
    // Any value at or above the limit rolls to zero so the digit stays in range.
    function automatic logic [4:0] bcd_step(input logic [3:0] digit,
                                            input logic [3:0] limit,
                                            input logic       carry_in);
        logic [4:0] result;
        if (!carry_in) begin
            result = {1'b0, digit};
        end else if (digit >= limit) begin
            result = {1'b1, 4'd0};
        end else begin
            result = {1'b0, digit + 4'd1};
        end
        return result;
    endfunction

    assign tick_evt  = TickIn & ~tick_prev;
    assign start_evt = Start  & ~start_prev;
    assign stop_evt  = Stop   & ~stop_prev;
    assign clear_evt = Clear  & ~clear_prev;

    // Only the pre-transition state gates counting; Clear suppresses the tick.
    assign count_en  = tick_evt && (state == RUN) && !clear_evt;

    always_comb begin
        sec0_step = bcd_step(Sec0, SEC0_MAX, count_en);
        sec1_step = bcd_step(Sec1, SEC1_MAX, sec0_step[4]);
        min0_step = bcd_step(Min0, MIN0_MAX, sec1_step[4]);
        min1_step = bcd_step(Min1, MIN1_MAX, min0_step[4]);
        wrap_next = min1_step[4];
    end

    // Button priority is Clear > Stop > Start; Stop in PAUSE still masks Start.
    always_comb begin
        state_next = state;
        if (clear_evt) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_evt) state_next = RUN;
                end
                RUN: begin
                    if (stop_evt) state_next = PAUSE;
                end
                PAUSE: begin
                    if (!stop_evt && start_evt) state_next = RUN;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            tick_prev  <= 1'b0;
            start_prev <= 1'b0;
            stop_prev  <= 1'b0;
            clear_prev <= 1'b0;
            Sec0       <= 4'd0;
            Sec1       <= 4'd0;
            Min0       <= 4'd0;
            Min1       <= 4'd0;
            Running    <= 1'b0;
            Wrap       <= 1'b0;
        end else begin
            state      <= state_next;
            tick_prev  <= TickIn;
            start_prev <= Start;
            stop_prev  <= Stop;
            clear_prev <= Clear;
            Running    <= (state_next == RUN);
            Wrap       <= wrap_next;
            if (clear_evt) begin
                Sec0 <= 4'd0;
                Sec1 <= 4'd0;
                Min0 <= 4'd0;
                Min1 <= 4'd0;
            end else begin
                Sec0 <= sec0_step[3:0];
                Sec1 <= sec1_step[3:0];
                Min0 <= min0_step[3:0];
                Min1 <= min1_step[3:0];
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: button control, BCD carries, wrap,
// simultaneous events and reset behaviour.
module tb_stopwatch_counter;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       TickIn = 1'b0;
    logic       Start = 1'b0;
    logic       Stop = 1'b0;
    logic       Clear = 1'b0;
    logic [3:0] Sec0;
    logic [3:0] Sec1;
    logic [3:0] Min0;
    logic [3:0] Min1;
    logic       Running;
    logic       Wrap;

    int errors = 0;
    int checks = 0;
    int wrap_cnt = 0;

    stopwatch_counter #(.MaxMinTens(5)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .TickIn  (TickIn),
        .Start   (Start),
        .Stop    (Stop),
        .Clear   (Clear),
        .Sec0    (Sec0),
        .Sec1    (Sec1),
        .Min0    (Min0),
        .Min1    (Min1),
        .Running (Running),
        .Wrap    (Wrap)
    );

    always #10 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; outputs are looked at 1 ns after the edge and Wrap pulses tallied.
    task automatic step();
        @(posedge Clk);
        #1;
        if (Wrap) wrap_cnt++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic tick();
        TickIn = 1'b1;
        step();
        TickIn = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_start();
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
    endtask

    task automatic press_stop();
        Stop = 1'b1;
        step();
        Stop = 1'b0;
        step();
    endtask

    task automatic press_clear();
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        step();
    endtask

    function automatic logic [15:0] t_now();
        return {Min1, Min0, Sec1, Sec0};
    endfunction

    initial begin
        // Reset state
        steps(3);
        Rst = 1'b0;
        step();
        check("reset_time", t_now(), 16'h0000);
        check("reset_running", Running, 1'b0);
        check("reset_wrap", Wrap, 1'b0);

        // Ticks while IDLE are ignored
        ticks(2);
        check("idle_ticks", t_now(), 16'h0000);

        // Start, three ticks spaced 10 cycles
        press_start();
        check("start_running", Running, 1'b1);
        for (int i = 0; i < 3; i++) begin
            TickIn = 1'b1;
            step();
            TickIn = 1'b0;
            steps(9);
        end
        check("three_ticks", t_now(), 16'h0003);
        check("three_ticks_wrap", wrap_cnt, 0);

        // Seconds-units carry
        ticks(6);
        check("at_0009", t_now(), 16'h0009);
        tick();
        check("at_0010", t_now(), 16'h0010);

        // Minutes-units carry into minutes tens
        ticks(589);
        check("at_0959", t_now(), 16'h0959);
        tick();
        check("at_1000", t_now(), 16'h1000);

        // Full wrap from 59:59
        press_clear();
        check("clear_running", Running, 1'b0);
        press_start();
        ticks(3599);
        check("at_5959", t_now(), 16'h5959);
        check("no_wrap_before", wrap_cnt, 0);
        TickIn = 1'b1;
        step();
        check("wrap_pulse", Wrap, 1'b1);
        check("wrap_time", t_now(), 16'h0000);
        TickIn = 1'b0;
        step();
        check("wrap_one_cycle", Wrap, 1'b0);
        check("wrap_running", Running, 1'b1);
        check("wrap_count", wrap_cnt, 1);

        // Stop together with a tick
        press_clear();
        press_start();
        ticks(5);
        check("at_0005", t_now(), 16'h0005);
        TickIn = 1'b1;
        Stop = 1'b1;
        step();
        check("stop_tick_time", t_now(), 16'h0006);
        check("stop_tick_running", Running, 1'b0);
        TickIn = 1'b0;
        Stop = 1'b0;
        step();
        ticks(3);
        check("paused_hold", t_now(), 16'h0006);
        press_stop();
        check("pause_stop_ignored", Running, 1'b0);
        press_start();
        check("resume_running", Running, 1'b1);
        tick();
        check("resume_tick", t_now(), 16'h0007);

        // Clear + Start + tick in the same cycle, then Start held
        Clear = 1'b1;
        Start = 1'b1;
        TickIn = 1'b1;
        step();
        check("clear_all_time", t_now(), 16'h0000);
        check("clear_all_running", Running, 1'b0);
        Clear = 1'b0;
        TickIn = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("held_start_running", Running, 1'b0);
        check("held_start_time", t_now(), 16'h0000);
        Start = 1'b0;
        step();

        // Reset mid-run at 12:34
        press_start();
        ticks(754);
        check("at_1234", t_now(), 16'h1234);
        wrap_cnt = 0;
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        check("rst_time", t_now(), 16'h0000);
        check("rst_running", Running, 1'b0);
        check("rst_wrap", Wrap, 1'b0);
        ticks(4);
        check("rst_ticks_ignored", t_now(), 16'h0000);

        // Start already high when reset releases counts as an edge
        Rst = 1'b1;
        Start = 1'b1;
        step();
        Rst = 1'b0;
        step();
        check("start_at_release", Running, 1'b1);
        Start = 1'b0;
        tick();
        check("start_at_release_tick", t_now(), 16'h0001);
        check("final_wrap_count", wrap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Stopwatch core that consumes the slow square wave produced by the board clock divider and keeps an MM:SS time in BCD. It sits directly downstream of the divider, in the same `Clk` domain. It detects rising edges of the divider output and counts them only while running, under Start/Stop/Clear button control. Its BCD digits feed the seven-segment display stage.

## Interface
- `MaxMinTens`, default 5: tens-of-minutes digit value at which the count wraps; with the default, 59:59 wraps to 00:00.
- `Clk`  in  1  system clock, 50 MHz board clock; the same clock that drives the divider.
- `Rst`  in  1  reset; synchronous and active-high.
- `TickIn`  in  1  divider output, a level; registered in the `Clk` domain; each rising edge = one count.
- `Start`  in  1  debounced button level; acts on its rising edge.
- `Stop`  in  1  debounced button level; acts on its rising edge.
- `Clear`  in  1  debounced button level; acts on its rising edge.
- `Sec0`  out  4  BCD seconds units, 0–9.
- `Sec1`  out  4  BCD seconds tens, 0–5.
- `Min0`  out  4  BCD minutes units, 0–9.
- `Min1`  out  4  BCD minutes tens, 0–`MaxMinTens`.
- `Running`  out  1  high while the state is RUN.
- `Wrap`  out  1  one-cycle pulse on the transition from max time to 00:00.

## Operation
- Edge detect:
  - `TickIn`, `Start`, `Stop` and `Clear` each have a one-register history: `TickPrev`, `StartPrev`, `StopPrev`, `ClearPrev`.
  - An event is input high and history low.
- State machine, 2-bit state register:
  - IDLE: digits zero, not counting. Start edge → RUN.
  - RUN: counting. Stop edge → PAUSE.
  - PAUSE: digits held. Start edge → RUN; Stop edge is ignored.
  - Any state, Clear edge → IDLE, with all digits forced to 0 on the same clock edge.
- Button priority within one cycle: Clear > Stop > Start.
- Counting:
  - A tick event increments the time only if the current state (before that clock edge's transition) is RUN.
  - Seconds units increment. At 9 they go to 0 and carry into seconds tens.
  - Seconds tens wrap 5→0 and carry into minutes units.
  - Minutes units wrap 9→0 and carry into minutes tens.
  - Minutes tens at `MaxMinTens` with an incoming carry go to 0, and `Wrap` asserts for that one cycle.
  - Digits never hold non-BCD values.
- Simultaneous events:
  - Tick + Stop edge in RUN: the tick is counted, and the next state is PAUSE.
  - Tick + Clear edge: Clear wins; digits go to 0 and no `Wrap` pulse is generated.
  - Tick + Start edge in IDLE or PAUSE: the tick is not counted; counting begins with the next tick.
- Reset:
  - State IDLE, all digits 0, `Running` 0, `Wrap` 0.
  - All history registers 0.
  - A `TickIn` or button level that is already high at reset release does produce an event on the first cycle after release. Because the state is IDLE, only a Start edge has any effect.
- Reset asserted mid-run overrides all inputs on that clock edge.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Tick latency:
  - `TickIn` is first sampled high at clock edge N (with `TickPrev` = 0).
  - The digits show the incremented value after edge N.
  - `Wrap`, if applicable, is high for the cycle following edge N only.
- Button latency: a button first sampled high at edge N changes the state, and `Running`, after edge N.
- Holding a button high produces exactly one event. A new event requires the input to go low for at least one `Clk` cycle.
- Tick spacing is at least 2 `Clk` cycles, which the divider guarantees. No tick is lost at that spacing.

## Test plan
- Reset, then a Start edge, then 3 `TickIn` rising edges spaced 10 cycles apart → `Running` = 1, `Sec0` = 3, all other digits 0, `Wrap` never asserted.
- Run to 00:09, send one tick → `Sec0` = 0, `Sec1` = 1. Run to 09:59, send one tick → 10:00.
- Preload to 59:59 by running 3599 ticks (short spacing), send one more tick → 00:00, `Wrap` = 1 for exactly one cycle, `Running` stays 1.
- At 00:05 in RUN, assert Stop on the same cycle as a tick → 00:06, `Running` = 0. Further ticks → still 00:06. Start edge, then one tick → 00:07.
- At 00:07, assert Clear together with Start and a tick → state IDLE, digits 00:00, `Running` = 0. Hold Start high for 20 cycles → no second event.
- Pulse `Rst` for one cycle while in RUN at 12:34 → on the next cycle, digits 00:00, `Running` = 0, `Wrap` = 0. Ticks with no Start edge → digits stay 00:00.
